// File: rtl/wb_spiflash_if.sv
// Wishbone classic slave bundle for the read-only SPI flash window.
interface wb_spiflash_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_spiflash.sv
// Read-only Wishbone window onto a serial flash: each word read issues one READ (0x03)
// command with a 24-bit address and shifts in 32 data bits, big-endian.
module wb_spiflash #(
    parameter int unsigned clk_div   = 2,
    parameter int unsigned adr_width = 24
) (
    input  logic         clk,
    input  logic         reset,
    wb_spiflash_if.slave wb,
    output logic         spi_cs_n,
    output logic         spi_sck,
    output logic         spi_mosi,
    input  logic         spi_miso
);

    typedef enum logic [1:0] {StIdle, StShift, StAck} state_e;

    localparam logic [7:0] DivLast = 8'(clk_div - 1);

    state_e      state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_q, div_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        abort_q, abort_d;

    logic        req;
    logic        phase_end;
    logic        last_fall;
    logic [63:0] cmd_word;
    logic        unused_wb;

    // While ack is high the master has not yet seen it, so a held strobe is not a new request.
    assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign phase_end = (div_q == DivLast);
    assign last_fall = phase_end & sck_q & (bit_cnt_q == 7'd63);
    assign cmd_word  = {8'h03, wb.wb_adr_i[adr_width-1:2], 2'b00, 32'h0};
    assign unused_wb = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:adr_width], wb.wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = wb.wb_we_i ? StAck : StShift;
                end
            end
            StShift: begin
                // An aborted cycle still finishes the flash command but gets no ack.
                if (last_fall) begin
                    state_d = (abort_q || !wb.wb_cyc_i) ? StIdle : StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        dat_d     = dat_q;
        abort_d   = abort_q;
        ack_d     = (state_q == StAck);
        case (state_q)
            StIdle: begin
                if (req && !wb.wb_we_i) begin
                    shift_d   = cmd_word;
                    bit_cnt_d = 7'd0;
                    div_d     = 8'd0;
                    sck_d     = 1'b0;
                    cs_n_d    = 1'b0;
                    mosi_d    = cmd_word[63];
                    abort_d   = 1'b0;
                end
            end
            StShift: begin
                abort_d = abort_q | ~wb.wb_cyc_i;
                if (phase_end) begin
                    div_d = 8'd0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        shift_d = {shift_q[62:0], spi_miso};
                    end else begin
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        if (last_fall) begin
                            cs_n_d = 1'b1;
                            mosi_d = 1'b0;
                            dat_d  = shift_q[31:0];
                        end else begin
                            mosi_d = shift_q[63];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= 64'h0;
            bit_cnt_q <= 7'd0;
            div_q     <= 8'd0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            dat_q     <= 32'h0;
            ack_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            abort_q   <= abort_d;
        end
    end

    assign spi_cs_n    = cs_n_q;
    assign spi_sck     = sck_q;
    assign spi_mosi    = mosi_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;

endmodule

// File: tb/tb_wb_spiflash.sv
// Bench: three flash windows (clk_div 2, 1, 5), each with a behavioural SPI flash holding
// byte[n] = n[7:0] ^ n[23:16]; latencies are counted from the edge after which a request is driven.
module tb_wb_spiflash;
    localparam int NDUT = 3;

    function automatic int unsigned cd_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NDUT-1:0] rst = '1;
    logic [NDUT-1:0] stb = '0;
    logic [NDUT-1:0] wcyc = '0;
    logic [NDUT-1:0] we = '0;
    logic [31:0]     adr [NDUT];
    logic [31:0]     wdat [NDUT];
    logic [3:0]      sel [NDUT];
    logic [31:0]     rdat [NDUT];
    logic [NDUT-1:0] ack;
    logic [NDUT-1:0] cs_n;
    logic [NDUT-1:0] sck;
    logic [NDUT-1:0] mosi;
    logic [NDUT-1:0] miso = '0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_spiflash_if bus ();
        assign bus.wb_adr_i = adr[g];
        assign bus.wb_dat_i = wdat[g];
        assign bus.wb_sel_i = sel[g];
        assign bus.wb_stb_i = stb[g];
        assign bus.wb_cyc_i = wcyc[g];
        assign bus.wb_we_i  = we[g];
        assign rdat[g]      = bus.wb_dat_o;
        assign ack[g]       = bus.wb_ack_o;

        wb_spiflash #(.clk_div(cd_of(g)), .adr_width(24)) dut (
            .clk      (clk),
            .reset    (rst[g]),
            .wb       (bus),
            .spi_cs_n (cs_n[g]),
            .spi_sck  (sck[g]),
            .spi_mosi (mosi[g]),
            .spi_miso (miso[g])
        );
    end

    // Flash contents and the expected Wishbone word, from flash byte order alone.
    function automatic logic [7:0] byte_at(input logic [23:0] n);
        return n[7:0] ^ n[23:16];
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {byte_at(b), byte_at(b + 24'd1), byte_at(b + 24'd2), byte_at(b + 24'd3)};
    endfunction

    function automatic logic flash_bit(input logic [23:0] a, input int j);
        logic [7:0] b;
        b = byte_at(a + 24'(j / 8));
        return b[7 - (j % 8)];
    endfunction

    // SPI-side monitor and mode-0 flash model, sampled on the falling clk edge.
    int          pulses [NDUT];
    int          rx [NDUT];
    logic [31:0] cmd [NDUT];
    int          mosi_nz [NDUT];
    int          phase_err [NDUT];
    int          setup [NDUT];
    int          hold_err [NDUT];
    int          sckcs_err [NDUT];
    int          cs_falls [NDUT];
    int unsigned gap [NDUT];
    int unsigned cs_fall_at [NDUT];
    int unsigned cs_rise_at [NDUT];
    int unsigned last_edge [NDUT];
    logic [NDUT-1:0] sck_p = '0;
    logic [NDUT-1:0] cs_p = '1;

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            pulses[g] = 0; rx[g] = 0; cmd[g] = 0; mosi_nz[g] = 0; phase_err[g] = 0;
            setup[g] = 0; hold_err[g] = 0; sckcs_err[g] = 0; cs_falls[g] = 0; gap[g] = 0;
            cs_fall_at[g] = 0; cs_rise_at[g] = 0; last_edge[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (cs_p[g] && !cs_n[g]) begin
                cs_falls[g]   <= cs_falls[g] + 1;
                cs_fall_at[g] <= cyc;
                gap[g]        <= cyc - cs_rise_at[g];
                last_edge[g]  <= cyc;
                pulses[g]     <= 0;
                rx[g]         <= 0;
                cmd[g]        <= 32'h0;
                mosi_nz[g]    <= 0;
                miso[g]       <= 1'b0;
            end
            if (!sck_p[g] && sck[g]) begin
                if (cyc - last_edge[g] != cd_of(g)) phase_err[g] <= phase_err[g] + 1;
                if (pulses[g] == 0) setup[g] <= cyc - cs_fall_at[g];
                last_edge[g] <= cyc;
                pulses[g]    <= pulses[g] + 1;
                rx[g]        <= rx[g] + 1;
                if (rx[g] < 32) cmd[g] <= {cmd[g][30:0], mosi[g]};
                else if (mosi[g]) mosi_nz[g] <= mosi_nz[g] + 1;
            end
            if (sck_p[g] && !sck[g]) begin
                if (cyc - last_edge[g] != cd_of(g)) phase_err[g] <= phase_err[g] + 1;
                last_edge[g] <= cyc;
                if (rx[g] >= 32 && rx[g] < 64) miso[g] <= flash_bit(cmd[g][23:0], rx[g] - 32);
            end
            if (!cs_p[g] && cs_n[g]) begin
                cs_rise_at[g] <= cyc;
                if (!(sck_p[g] && !sck[g])) hold_err[g] <= hold_err[g] + 1;
            end
            if (cs_n[g] && sck[g]) sckcs_err[g] <= sckcs_err[g] + 1;
        end
        sck_p <= sck;
        cs_p  <= cs_n;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int g, input logic [31:0] a, input bit hold, input bit chk_gap);
        int unsigned t0;
        int ph0, ho0;
        bit got;
        ph0 = phase_err[g];
        ho0 = hold_err[g];
        adr[g]  = a;
        wdat[g] = $urandom();
        sel[g]  = 4'($urandom_range(0, 15));
        we[g]   = 1'b0;
        stb[g]  = 1'b1;
        wcyc[g] = 1'b1;
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick();
            if (ack[g]) got = 1'b1;
        end
        chk("rd_ack_seen", 64'(got), 64'd1);
        chk("rd_latency", 64'(cyc - t0), 64'(2 + 128 * cd_of(g)));
        chk("rd_data", 64'(rdat[g]), 64'(exp_word(a)));
        chk("rd_sck_pulses", 64'(pulses[g]), 64'd64);
        chk("rd_mosi_cmd", 64'(cmd[g]), 64'({8'h03, a[23:2], 2'b00}));
        chk("rd_mosi_data_zero", 64'(mosi_nz[g]), 64'd0);
        chk("rd_sck_phase", 64'(phase_err[g] - ph0), 64'd0);
        chk("rd_cs_setup", 64'(setup[g]), 64'(cd_of(g)));
        chk("rd_cs_hold", 64'(hold_err[g] - ho0), 64'd0);
        if (chk_gap) chk("rd_deselect_ge2", 64'(gap[g] >= 2), 64'd1);
        if (!hold) begin
            stb[g]  = 1'b0;
            wcyc[g] = 1'b0;
        end
        tick();
        chk("rd_ack_width", 64'(ack[g]), 64'd0);
    endtask

    task automatic wr(input int g, input logic [31:0] a, input logic [31:0] d);
        int unsigned t0;
        int f0;
        bit got;
        f0 = cs_falls[g];
        adr[g]  = a;
        wdat[g] = d;
        sel[g]  = 4'hf;
        we[g]   = 1'b1;
        stb[g]  = 1'b1;
        wcyc[g] = 1'b1;
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (ack[g]) got = 1'b1;
        end
        chk("wr_ack_seen", 64'(got), 64'd1);
        chk("wr_latency", 64'(cyc - t0), 64'd2);
        stb[g]  = 1'b0;
        wcyc[g] = 1'b0;
        we[g]   = 1'b0;
        tick();
        chk("wr_ack_width", 64'(ack[g]), 64'd0);
        repeat (4) tick();
        chk("wr_no_cs", 64'(cs_falls[g] - f0), 64'd0);
    endtask

    // Starts a read and returns once the given SCK pulse count is reached.
    task automatic start_and_wait(input int g, input logic [31:0] a, input int npulse);
        int f0;
        bit hit;
        f0 = cs_falls[g];
        adr[g]  = a;
        we[g]   = 1'b0;
        stb[g]  = 1'b1;
        wcyc[g] = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (cs_falls[g] != f0 && pulses[g] >= npulse) hit = 1'b1;
        end
        chk("reach_pulse", 64'(hit), 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        bit saw_ack, done;
        for (int g = 0; g < NDUT; g++) begin
            adr[g] = 32'h0; wdat[g] = 32'h0; sel[g] = 4'h0;
        end
        repeat (3) tick();
        for (int g = 0; g < NDUT; g++)
            chk("reset_state", 64'({cs_n[g], sck[g], mosi[g], ack[g], rdat[g]}),
                64'({4'b1000, 32'h0}));
        rst = '0;
        tick();

        rd(0, 32'hA000_0104, 1'b0, 1'b0);
        chk("single_read_word", 64'(rdat[0]), 64'h0405_0607);

        rd(0, 32'hA000_0000, 1'b1, 1'b0);
        rd(0, 32'hA000_0004, 1'b0, 1'b1);

        wr(0, 32'hA000_0010, 32'hDEAD_BEEF);
        rd(0, 32'hA000_0010, 1'b0, 1'b0);

        // Abort: master drops the cycle mid-transfer.
        start_and_wait(0, 32'hA000_0020, 20);
        stb[0]  = 1'b0;
        wcyc[0] = 1'b0;
        saw_ack = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (ack[0]) saw_ack = 1'b1;
            if (cs_n[0]) done = 1'b1;
        end
        repeat (5) begin
            tick();
            if (ack[0]) saw_ack = 1'b1;
        end
        chk("abort_cs_release", 64'(done), 64'd1);
        chk("abort_no_ack", 64'(saw_ack), 64'd0);
        chk("abort_pulses", 64'(pulses[0]), 64'd64);
        chk("abort_data", 64'(rdat[0]), 64'(exp_word(32'hA000_0020)));
        rd(0, 32'hA000_0030, 1'b0, 1'b0);

        // Reset while the flash command is in flight.
        start_and_wait(0, 32'hA000_0040, 30);
        rst[0] = 1'b1;
        tick();
        chk("rst_mid_outputs", 64'({cs_n[0], sck[0], mosi[0], ack[0], rdat[0]}),
            64'({4'b1000, 32'h0}));
        rst[0]  = 1'b0;
        stb[0]  = 1'b0;
        wcyc[0] = 1'b0;
        tick();
        rd(0, 32'hA000_0044, 1'b0, 1'b0);

        rd(1, 32'hA000_0104, 1'b0, 1'b0);
        rd(2, 32'hA000_0104, 1'b0, 1'b0);

        for (int g = 0; g < NDUT; g++) begin
            for (int k = 0; k < 3; k++) begin
                a = $urandom();
                a[31:29] = 3'b101;
                if ($urandom_range(0, 3) == 0) wr(g, a, $urandom());
                else rd(g, a, 1'b0, 1'b0);
            end
        end

        for (int g = 0; g < NDUT; g++)
            chk("sck_low_when_deselected", 64'(sckcs_err[g]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
